// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode handshake.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  // Fetch controller side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one imem read at a time, buffers
// {instr, pc} pairs in a small FIFO toward decode, and steers the PC register.
module fetch_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  pc,
  output logic [31:0]  pc_next,
  output logic         pc_write,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_ctrl_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t             state_q, state_d;
  logic [31:0]        req_pc_q;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               issue, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue/redirect decisions, PC steering and next state
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    pc_next      = pc;
    pc_write     = 1'b0;
    bus.imem_req = 1'b0;
    if (!rst_n) begin
      pc_next  = RESET_PC;
      pc_write = 1'b1;
    end else begin
      issue = (state_q == S_IDLE) && (count_q < CNT_FULL) && !redirect_valid;
      push  = (state_q == S_WAIT) && bus.imem_rvalid && !redirect_valid;
      pop   = (count_q != '0) && bus.id_ready && !redirect_valid;
      if (redirect_valid) begin
        pc_next  = redirect_pc;
        pc_write = 1'b1;
      end else if (issue) begin
        pc_next      = pc + 32'd4;
        pc_write     = 1'b1;
        bus.imem_req = 1'b1;
      end
      case (state_q)
        S_IDLE: if (issue) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.imem_rvalid)     state_d = S_IDLE;
          else if (redirect_valid) state_d = S_DROP;
        end
        S_DROP: if (bus.imem_rvalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, request tag and FIFO storage; redirect flushes and cancels push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (issue) req_pc_q <= pc;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: req_pc_q};
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Address follows the PC; decode sees the FIFO head
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_instr  = mem_q[rd_ptr_q].instr;
  assign bus.if_pc     = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register plant, latency-randomised memory, and a
// queue-based reference model compared against the DUT every cycle.
module tb_fetch_ctrl;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_ctrl_if bus();

  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_next        (pc_next),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // PC register loaded from the controller
  always @(posedge clk) if (pc_write) pc <= pc_next;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  // reference model: outstanding flag, discard flag, queue of buffered pairs
  ent_t        mq[$];
  bit          m_out, m_drop;
  logic [31:0] m_req_pc;
  logic [31:0] m_last_pc_next;
  bit          m_last_pw, m_last_req;

  resp_t       resp_q[$];
  logic [31:0] req_log[$];
  ent_t        pop_log[$];
  bit          pw_log[$];

  int unsigned cyc;
  int          lat_fixed;
  bit          spur_en;
  int          n_chk, n_pass;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic ent_t pop_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : {64{1'bx}};
  endfunction

  // Compare DUT against the model, then advance the model and the memory
  task automatic compare_and_update();
    bit          e_issue, e_pw;
    logic [31:0] e_pc_next;
    resp_t       r;
    if (!rst_n) begin
      check1 ("rst_pc_write", pc_write, 1'b1);
      check32("rst_pc_next",  pc_next, RST_PC);
      check1 ("rst_imem_req", bus.imem_req, 1'b0);
      check1 ("rst_if_valid", bus.if_valid, 1'b0);
      check32("rst_if_instr", bus.if_instr, 32'h0);
      check32("rst_if_pc",    bus.if_pc, 32'h0);
      return;
    end
    e_issue   = !m_out && (mq.size() < int'(DEPTH)) && !redirect_valid;
    e_pw      = redirect_valid || e_issue;
    e_pc_next = redirect_valid ? redirect_pc : (e_issue ? pc + 32'd4 : pc);
    m_last_pc_next = e_pc_next;
    m_last_pw      = e_pw;
    m_last_req     = e_issue;

    check1 ("imem_req",  bus.imem_req, e_issue);
    check32("imem_addr", bus.imem_addr, pc);
    check32("pc_next",   pc_next, e_pc_next);
    check1 ("pc_write",  pc_write, e_pw);
    check1 ("if_valid",  bus.if_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check32("if_instr", bus.if_instr, mq[0].instr);
      check32("if_pc",    bus.if_pc, mq[0].pc);
    end

    if (e_issue) req_log.push_back(pc);
    pw_log.push_back(e_pw);

    // memory accepts the request the DUT actually makes
    if (bus.imem_req) begin
      r.due  = cyc + ((lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4));
      if (resp_q.size() != 0 && r.due <= resp_q[$].due) r.due = resp_q[$].due + 1;
      r.data = mem_f(bus.imem_addr);
      resp_q.push_back(r);
    end

    if (redirect_valid) begin
      mq.delete();
      if (m_out) begin
        if (bus.imem_rvalid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (mq.size() != 0 && bus.id_ready) pop_log.push_back(mq.pop_front());
      if (m_out && bus.imem_rvalid) begin
        if (!m_drop) mq.push_back({bus.imem_rdata, m_req_pc});
        m_out  = 0;
        m_drop = 0;
      end
      if (e_issue) begin
        m_out    = 1;
        m_drop   = 0;
        m_req_pc = pc;
      end
    end
  endtask

  // One clock: drive memory response, compare at negedge, return after posedge
  task automatic step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = resp_q[0].data;
      void'(resp_q.pop_front());
    end else if (spur_en && rst_n && resp_q.size() == 0 && !m_out && $urandom_range(0, 19) == 0) begin
      bus.imem_rvalid = 1'b1;
    end
    @(negedge clk);
    compare_and_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit stale);
    resp_t r;
    rst_n = 1'b0;
    #1;
    check1("async_rst_if_valid", bus.if_valid, 1'b0);
    check1("async_rst_imem_req", bus.imem_req, 1'b0);
    resp_q.delete();
    mq.delete();
    m_out = 0;
    m_drop = 0;
    redirect_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    if (stale) begin
      r.due  = cyc;
      r.data = 32'hDEAD_BEEF;
      resp_q.push_back(r);
    end
    req_log.delete();
    pop_log.delete();
    pw_log.delete();
  endtask

  initial begin
    logic [7:0] pw_vec;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;
    cyc = 0; n_chk = 0; n_pass = 0;
    lat_fixed = 1; spur_en = 0;
    @(posedge clk);
    #1;

    // sequential fetch, L=1, decode always ready
    do_reset(0);
    bus.id_ready = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      check32("seq_imem_addr", req_at(i), 32'(4 * i));
      check32("seq_if_pc", pop_at(i).pc, 32'(4 * i));
      check32("seq_if_instr", pop_at(i).instr, mem_f(32'(4 * i)));
    end
    for (int i = 0; i < 8; i++) pw_vec[i] = (pw_log.size() > i) ? pw_log[i] : 1'b0;
    check32("seq_pc_write_pattern", 32'(pw_vec), 32'h55);

    // backpressure: decode stalled for 10 cycles
    do_reset(0);
    bus.id_ready = 1'b0;
    repeat (10) step();
    check32("bp_req_count", 32'(req_log.size()), 32'd2);
    check1 ("bp_if_valid", bus.if_valid, 1'b1);
    check32("bp_if_pc", bus.if_pc, 32'h0);
    bus.id_ready = 1'b1;
    repeat (3) step();
    check32("bp_req_after_pop", 32'(req_log.size()), 32'd3);
    check32("bp_third_addr", req_at(2), 32'h8);

    // redirect while the read of 8 is outstanding, L=3
    do_reset(0);
    lat_fixed = 3;
    for (int c = 0; c < 16; c++) begin
      bus.id_ready   = (c == 4);
      redirect_valid = (c == 9);
      redirect_pc    = 32'h0000_0100;
      if (c == 9) check1("rw_pre_flush_valid", bus.if_valid, 1'b1);
      step();
      if (c == 9)  check1("rw_flushed", bus.if_valid, 1'b0);
      if (c == 11) check32("rw_no_req_before_drop", 32'(req_log.size()), 32'd3);
    end
    redirect_valid = 1'b0;
    check32("rw_addr0", req_at(0), 32'h0);
    check32("rw_addr2", req_at(2), 32'h8);
    check32("rw_addr3", req_at(3), 32'h100);
    check32("rw_pops", 32'(pop_log.size()), 32'd1);

    // redirect coinciding with rvalid and a pop
    do_reset(0);
    lat_fixed = 1;
    bus.id_ready = 1'b0;
    repeat (3) step();
    bus.id_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    check32("rc_pc_next", m_last_pc_next, 32'h200);
    check1 ("rc_pc_write", m_last_pw, 1'b1);
    check1 ("rc_no_req", m_last_req, 1'b0);
    check1 ("rc_dut_if_valid", bus.if_valid, 1'b0);
    check32("rc_no_pop", 32'(pop_log.size()), 32'd0);
    redirect_valid = 1'b0;
    step();
    check32("rc_next_addr", req_at(2), 32'h200);

    // wrap-around of the sequential PC
    do_reset(0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check32("wrap_pc_next", m_last_pc_next, 32'h0);
    repeat (3) step();
    check32("wrap_addr0", req_at(0), 32'hFFFF_FFFC);
    check32("wrap_addr1", req_at(1), 32'h0);
    check32("wrap_pop_pc", pop_at(0).pc, 32'hFFFF_FFFC);

    // async reset in WAIT, stale response arrives just after release
    do_reset(0);
    lat_fixed = 3;
    step();
    do_reset(1);
    repeat (6) step();
    check32("ar_restart_addr", req_at(0), RST_PC);
    check32("ar_pop_pc", pop_at(0).pc, RST_PC);
    check32("ar_pop_instr", pop_at(0).instr, mem_f(RST_PC));

    // randomized traffic
    do_reset(0);
    lat_fixed = 0;
    spur_en   = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.id_ready   = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(0, 1) == 1);
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller placed directly downstream of the PC register. Each cycle it takes the current program counter and issues at most one instruction-memory read. It buffers returned instructions, tagged with their PC, in a small FIFO that feeds the decode stage through a valid/ready handshake. It also computes the next PC (sequential +4 or redirect target) and tells the PC register when to load it.

## Interface
- DEPTH, 2, number of FIFO entries (instruction and PC pairs), minimum 2
- RESET_PC, 32'h0000_0000, PC value loaded into the PC register while reset is asserted

- clk  in  1  clock; every flop updates on the rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- pc  in  32  current PC from the PC register
- pc_next  out  32  value the PC register loads
- pc_write  out  1  PC register load enable
- redirect_valid  in  1  branch/jump redirect request from the execute stage
- redirect_pc  in  32  redirect target
- imem_req  out  1  read request, valid for one cycle
- imem_addr  out  32  read address, equal to pc
- imem_rvalid  in  1  read data valid; one cycle, arrives 1 or more cycles after the request
- imem_rdata  in  32  instruction word
- if_valid  out  1  FIFO head valid toward decode
- if_instr  out  32  FIFO head instruction
- if_pc  out  32  FIFO head PC
- id_ready  in  1  decode accepts the head

## Operation
- State machine with three states:
  - IDLE: no read outstanding.
  - WAIT: one read outstanding.
  - DROP: one read outstanding, and its response will be discarded.
- Issue condition: state==IDLE, count<DEPTH, redirect_valid==0.
- In an issue cycle, all of the following hold combinationally:
  - imem_req=1 and imem_addr=pc
  - pc_next=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0)
  - pc_write=1
  - next state is WAIT, and the issued pc is latched as req_pc
- Transitions on imem_rvalid:
  - WAIT: push {imem_rdata, req_pc} into the FIFO, then go to IDLE.
  - DROP: discard the data, then go to IDLE.
  - IDLE: the response is ignored (protocol error; it must not corrupt state).
- Redirect (redirect_valid=1) has highest priority:
  - pc_next=redirect_pc, pc_write=1, imem_req=0.
  - The FIFO is flushed: count is set to 0 and any simultaneous push or pop is cancelled.
  - Next state by current state:
    - IDLE stays IDLE.
    - WAIT with rvalid=0 goes to DROP.
    - WAIT with rvalid=1 discards the data and goes to IDLE.
    - DROP with rvalid=1 goes to IDLE; DROP with rvalid=0 stays in DROP.
- Outside issue and redirect cycles: pc_write=0 and pc_next=pc.
- FIFO:
  - Pop occurs on if_valid && id_ready.
  - If push and pop happen in the same cycle, count is unchanged and order is preserved.
  - Overflow is impossible by construction, because issue requires count<DEPTH and only one read is ever outstanding.
- if_valid = (count!=0). if_instr and if_pc come from the head entry and are held stable while if_valid && !id_ready.
- While rst_n=0:
  - pc_write=1 and pc_next=RESET_PC, so the PC register is initialised.
  - imem_req=0.

## Timing
- Reset values: state IDLE, count 0, if_valid 0, imem_req 0, if_instr 0, if_pc 0, req_pc 0.
  - During reset: pc_write 1, pc_next RESET_PC.
- The first issue happens in the first cycle after rst_n deasserts, once pc has been loaded.
- Latency: request in cycle N, imem_rvalid in cycle N+L (L≥1), if_valid high in cycle N+L+1.
- Throughput:
  - With L=1 and decode always ready, one instruction every 2 cycles: issue, then response, then issue again.
  - Back-to-back issue in the response cycle is not permitted.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and any outstanding response is ignored because the state is IDLE.
- pc_next, pc_write and imem_req are combinational from the registered state and the inputs. There is no combinational path from imem_rdata to any output other than through the FIFO.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0, L=1, id_ready=1.
  - Required: imem_addr sequence 0,4,8,C, and if_pc sequence 0,4,8,C carrying the matching imem_rdata. pc_write pulses every 2nd cycle.
- Backpressure:
  - Stimulus: id_ready=0 for 10 cycles.
  - Required: exactly 2 requests issued. count=2, if_valid=1, if_pc=0 held stable. No third imem_req until a pop.
- Redirect while WAIT with L=3:
  - Stimulus: redirect_pc=32'h0000_0100 during the outstanding read of addr 8.
  - Required: the response for 8 is dropped, the FIFO empties, and the next imem_addr is 0x100 once the dropped response returns.
- Redirect coincident with rvalid and with a pop:
  - Required: the data is discarded, count=0, and the state returns to IDLE with pc_next=redirect_pc.
- Wrap-around:
  - Stimulus: pc=32'hFFFF_FFFC.
  - Required: pc_next=0.
- Async reset mid-WAIT:
  - Stimulus: a late imem_rvalid arrives after reset release.
  - Required: the late response is ignored, if_valid=0, and fetch restarts at RESET_PC.
